// File: rtl/wave_pkg.sv
// Shared waveform type codes and period derivation for the generator/classifier pair.
package wave_pkg;
    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_NONE   = 2'd3
    } wave_t;

    localparam int NUM_TYPES = 3;

    function automatic int period_of(input int t, input int amp, input int sq_half);
        case (t)
            0:       return 2 * sq_half;
            1:       return amp + 1;
            default: return 2 * amp;
        endcase
    endfunction
endpackage

// File: rtl/wave_period_tracker.sv
// Per-waveform candidate tracker: survives while step, period, timeout and half-period rules hold.
module wave_period_tracker #(
    parameter int CW     = 6,
    parameter int PERIOD = 20,
    parameter int HALF   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    input  logic evt,
    input  logic step_bad,
    input  logic half_evt,
    output logic ok,
    output logic viol,
    output logic period_good
);
    logic          seen;
    logic [CW-1:0] c;
    logic [CW-1:0] cnt1;

    // cnt1 is the number of samples since the last event, counting this one
    always_comb begin
        cnt1 = c + CW'(1);
        viol = ok & en & (step_bad
                          | (seen & (cnt1 > CW'(PERIOD)))
                          | (seen & evt & (cnt1 != CW'(PERIOD)))
                          | (seen & half_evt & (cnt1 != CW'(HALF))));
        period_good = ok & en & evt & seen & ~viol;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok   <= 1'b1;
            seen <= 1'b0;
            c    <= '0;
        end else if (restart) begin
            ok   <= 1'b1;
            seen <= 1'b0;
            c    <= '0;
        end else if (en && ok) begin
            if (viol) begin
                ok <= 1'b0;
            end else if (evt) begin
                seen <= 1'b1;
                c    <= '0;
            end else if (seen) begin
                c <= cnt1;
            end
        end
    end
endmodule

// File: rtl/wave_classifier.sv
// Identifies square/sawtooth/triangle from a 5-bit sample stream and reports type and period.
module wave_classifier
    import wave_pkg::*;
#(
    parameter int AMP     = 20,
    parameter int SQ_HALF = 10,
    parameter int CW      = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    wave_in,
    output logic [1:0]    wave_type,
    output logic          locked,
    output logic [CW-1:0] period,
    output logic          err
);
    typedef enum logic {ACQUIRE, LOCKED} state_t;

    localparam logic [4:0]    A5    = 5'(AMP);
    localparam logic [CW-1:0] P_SQ  = CW'(period_of(0, AMP, SQ_HALF));
    localparam logic [CW-1:0] P_SAW = CW'(period_of(1, AMP, SQ_HALF));
    localparam logic [CW-1:0] P_TRI = CW'(period_of(2, AMP, SQ_HALF));

    state_t                 state;
    logic [4:0]             prev;
    logic                   primed;
    logic [5:0]             w6, p6;
    logic                   up, dn, drop;
    logic [NUM_TYPES-1:0]   evt, step_bad, half_evt, ok, viol, pg, ok_next;
    logic [3:0]             viol4;
    logic                   restart, all_dead, lock_hit, lock_viol;
    wave_t                  lk_type;
    logic [CW-1:0]          lk_period;

    always_comb begin
        w6   = {1'b0, wave_in};
        p6   = {1'b0, prev};
        up   = (w6 == p6 + 6'd1);
        dn   = (w6 + 6'd1 == p6);
        drop = (prev == A5) && (wave_in == 5'd0);

        step_bad[0] = !((wave_in == 5'd0) || (wave_in == A5));
        step_bad[1] = !(up || drop);
        step_bad[2] = !((up && prev != A5) || (dn && prev != 5'd0));
        evt[0]      = (prev == 5'd0) && (wave_in == A5);
        evt[1]      = drop;
        evt[2]      = (prev == 5'd1) && (wave_in == 5'd0);
        half_evt    = {2'b00, drop};

        ok_next   = ok & ~viol;
        all_dead  = primed && (ok_next == '0);
        // lock only when the single surviving candidate closes a correct period
        lock_hit  = primed && ((pg & ok_next) != '0)
                    && ((ok_next & (ok_next - 3'd1)) == '0);
        viol4     = {1'b0, viol};
        lock_viol = primed && viol4[wave_type];
        restart   = (state == ACQUIRE) ? all_dead : lock_viol;

        lk_type   = WAVE_TRI;
        lk_period = P_TRI;
        if (pg[0]) begin
            lk_type   = WAVE_SQUARE;
            lk_period = P_SQ;
        end else if (pg[1]) begin
            lk_type   = WAVE_SAW;
            lk_period = P_SAW;
        end
    end

    for (genvar i = 0; i < NUM_TYPES; i++) begin : g_trk
        wave_period_tracker #(
            .CW(CW),
            .PERIOD(period_of(i, AMP, SQ_HALF)),
            .HALF(i == 0 ? SQ_HALF : 0)
        ) u_trk (
            .clk(clk),
            .rst_n(rst_n),
            .en(primed),
            .restart(restart),
            .evt(evt[i]),
            .step_bad(step_bad[i]),
            .half_evt(half_evt[i]),
            .ok(ok[i]),
            .viol(viol[i]),
            .period_good(pg[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACQUIRE;
            prev      <= '0;
            primed    <= 1'b0;
            wave_type <= WAVE_NONE;
            locked    <= 1'b0;
            period    <= '0;
            err       <= 1'b0;
        end else begin
            prev   <= wave_in;
            primed <= 1'b1;
            err    <= 1'b0;
            case (state)
                ACQUIRE: if (lock_hit) begin
                    state     <= LOCKED;
                    locked    <= 1'b1;
                    wave_type <= lk_type;
                    period    <= lk_period;
                end
                LOCKED: if (lock_viol) begin
                    state     <= ACQUIRE;
                    err       <= 1'b1;
                    locked    <= 1'b0;
                    wave_type <= WAVE_NONE;
                    period    <= '0;
                end
                default: state <= ACQUIRE;
            endcase
        end
    end
endmodule

// File: tb/tb_wave_classifier.sv
// Directed scenarios plus randomized segments checked against an event-index reference model.
module tb_wave_classifier;
    localparam int AMP = 20;
    localparam int SQH = 10;
    localparam int CW  = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    wave_in = '0;
    logic [1:0]    wave_type;
    logic          locked;
    logic [CW-1:0] period;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    wave_classifier #(.AMP(AMP), .SQ_HALF(SQH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .wave_in(wave_in),
        .wave_type(wave_type), .locked(locked), .period(period), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: tracks the sample index of each type's last event.
    int m_idx, m_prev, m_type;
    bit m_primed, m_locked, m_err;
    bit m_alive[3];
    int m_last[3];

    function automatic int per(input int t);
        return (t == 0) ? 2 * SQH : (t == 1) ? AMP + 1 : 2 * AMP;
    endfunction

    function automatic int gen(input int t, input int k);
        int m;
        case (t)
            0: return ((k % 20) < 10) ? 0 : AMP;
            1: return k % 21;
            default: begin
                m = k % 40;
                return (m <= AMP) ? m : 40 - m;
            end
        endcase
    endfunction

    function automatic bit is_ev(input int t, input int p, input int v);
        case (t)
            0: return p == 0 && v == AMP;
            1: return p == AMP && v == 0;
            default: return p == 1 && v == 0;
        endcase
    endfunction

    function automatic bit violates(input int t, input int p, input int v);
        bit bad;
        int d;
        case (t)
            0: bad = !(v == 0 || v == AMP);
            1: bad = !(v == p + 1 || (p == AMP && v == 0));
            default: bad = !((v == p + 1 && p != AMP) || (v == p - 1 && p != 0));
        endcase
        if (m_last[t] >= 0) begin
            d = m_idx - m_last[t];
            if (d > per(t)) bad = 1;
            if (is_ev(t, p, v) && d != per(t)) bad = 1;
            if (t == 0 && p == AMP && v == 0 && d != SQH) bad = 1;
        end
        return bad;
    endfunction

    task automatic model_restart();
        for (int t = 0; t < 3; t++) begin
            m_alive[t] = 1;
            m_last[t]  = -1;
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_prev = 0; m_type = 3;
        m_primed = 0; m_locked = 0; m_err = 0;
        model_restart();
    endtask

    task automatic model_step(input int v);
        int n, hit;
        m_err = 0;
        if (!m_primed) begin
            m_primed = 1;
        end else if (m_locked) begin
            if (violates(m_type, m_prev, v)) begin
                m_err = 1; m_locked = 0; m_type = 3;
                model_restart();
            end else if (is_ev(m_type, m_prev, v)) begin
                m_last[m_type] = m_idx;
            end
        end else begin
            n = 0; hit = -1;
            for (int t = 0; t < 3; t++) begin
                if (m_alive[t]) begin
                    if (violates(t, m_prev, v)) m_alive[t] = 0;
                    else if (is_ev(t, m_prev, v)) begin
                        if (m_last[t] >= 0) hit = t;
                        m_last[t] = m_idx;
                    end
                end
                if (m_alive[t]) n++;
            end
            if (n == 0) model_restart();
            else if (n == 1 && hit >= 0) begin
                m_locked = 1; m_type = hit;
            end
        end
        m_prev = v;
        m_idx++;
    endtask

    task automatic drive(input int v);
        wave_in = 5'(v);
        @(posedge clk);
        #1;
        model_step(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wave_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({wave_type, locked, period, err} !== {2'd3, 1'b0, 6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: type=%0d locked=%0d period=%0d err=%0d, want 3/0/0/0",
                     wave_type, locked, period, err);
        end
    endtask

    task automatic test_lock(input int t, input int last_k, input int want_per);
        int errs = 0;
        do_reset();
        for (int k = 0; k <= last_k; k++) begin
            drive(gen(t, k));
            if (err) errs++;
            if (k == last_k - 1) begin
                n_tests++;
                if (locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL early_lock_t%0d: locked=%0d at k=%0d, want 0", t, locked, k);
                end
            end
        end
        n_tests++;
        if (locked !== 1'b1 || wave_type !== 2'(t) || period !== CW'(want_per)) begin
            n_fail++;
            $display("FAIL lock_t%0d: locked=%0d type=%0d period=%0d, want 1/%0d/%0d",
                     t, locked, wave_type, period, t, want_per);
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL acquire_err_t%0d: %0d err pulses, want 0", t, errs);
        end
    endtask

    task automatic test_constant();
        int bad = 0;
        do_reset();
        for (int k = 0; k < 200; k++) begin
            drive(0);
            if (err || locked) bad++;
        end
        n_tests++;
        if (bad != 0 || wave_type !== 2'd3) begin
            n_fail++;
            $display("FAIL constant: %0d cycles with err/locked, type=%0d, want 0 and 3", bad, wave_type);
        end
    endtask

    task automatic test_glitch();
        int errs = 0;
        do_reset();
        for (int k = 0; k < 50; k++) drive(k % 21);
        n_tests++;
        if (locked !== 1'b1 || wave_type !== 2'd1) begin
            n_fail++;
            $display("FAIL glitch_prelock: locked=%0d type=%0d, want 1/1", locked, wave_type);
        end
        drive(7);
        n_tests++;
        if (err !== 1'b1 || locked !== 1'b0 || wave_type !== 2'd3 || period !== '0) begin
            n_fail++;
            $display("FAIL glitch_err: err=%0d locked=%0d type=%0d period=%0d, want 1/0/3/0",
                     err, locked, wave_type, period);
        end
        drive(9);
        n_tests++;
        if (err !== 1'b0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_pulse: err=%0d locked=%0d, want 0/0", err, locked);
        end
        for (int k = 52; k <= 84; k++) begin
            drive(k % 21);
            if (err) errs++;
            if (k == 83) begin
                n_tests++;
                if (locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch_early_relock: locked=%0d, want 0", locked);
                end
            end
        end
        n_tests++;
        if (locked !== 1'b1 || wave_type !== 2'd1 || period !== 6'd21 || errs != 0) begin
            n_fail++;
            $display("FAIL glitch_relock: locked=%0d type=%0d period=%0d errs=%0d, want 1/1/21/0",
                     locked, wave_type, period, errs);
        end
    endtask

    task automatic test_reset_midlock();
        do_reset();
        for (int k = 0; k < 36; k++) drive(gen(0, k));
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({wave_type, locked, period, err} !== {2'd3, 1'b0, 6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: type=%0d locked=%0d period=%0d err=%0d, want 3/0/0/0",
                     wave_type, locked, period, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k <= 30; k++) drive(gen(0, k));
        n_tests++;
        if (locked !== 1'b1 || wave_type !== 2'd0 || period !== 6'd20) begin
            n_fail++;
            $display("FAIL reset_relock: locked=%0d type=%0d period=%0d, want 1/0/20",
                     locked, wave_type, period);
        end
    endtask

    task automatic test_mode_switch();
        int errs = 0;
        do_reset();
        for (int k = 0; k < 40; k++) drive(gen(0, k));
        for (int tk = 0; tk <= 80; tk++) begin
            drive(gen(2, tk));
            if (err) errs++;
            if (tk == 1) begin
                n_tests++;
                if (err !== 1'b1 || locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL switch_err: err=%0d locked=%0d, want 1/0", err, locked);
                end
            end
        end
        n_tests++;
        if (locked !== 1'b1 || wave_type !== 2'd2 || period !== 6'd40 || errs != 1) begin
            n_fail++;
            $display("FAIL switch_relock: locked=%0d type=%0d period=%0d errs=%0d, want 1/2/40/1",
                     locked, wave_type, period, errs);
        end
    endtask

    task automatic test_random();
        int ty, ph, len, gl, v, cst, ep;
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 9) == 0) do_reset();
            ty  = $urandom_range(0, 3);
            ph  = $urandom_range(0, 39);
            len = $urandom_range(20, 130);
            cst = $urandom_range(0, 31);
            gl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            for (int k = 0; k < len; k++) begin
                v = (ty == 3) ? cst : gen(ty, ph + k);
                if (k == gl) v = $urandom_range(0, 31);
                drive(v);
                ep = m_locked ? per(m_type) : 0;
                n_tests++;
                if (locked !== m_locked || wave_type !== 2'(m_type) ||
                    period !== CW'(ep) || err !== m_err) begin
                    n_fail++;
                    $display("FAIL random seg%0d k%0d: locked=%0d type=%0d period=%0d err=%0d, want %0d/%0d/%0d/%0d",
                             seg, k, locked, wave_type, period, err, m_locked, m_type, ep, m_err);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock(0, 30, 20);
        test_lock(1, 42, 21);
        test_lock(2, 80, 40);
        test_constant();
        test_glitch();
        test_reset_midlock();
        test_mode_switch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
